// File: rtl/grf_trace_sink_if.sv
// Write-back trace bundle plus the record output stream of grf_trace_sink.
// The sink side consumes the trace and presents records; the master side is the core/host.
interface grf_trace_sink_if;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata;
  logic [31:0] w_inst_addr;

  // Record stream: a record transfers on a rising edge where out_valid && out_ready.
  // out_valid is never withdrawn and the head fields never change until that transfer;
  // out_ready may toggle freely and is never required before out_valid.
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_addr;
  logic [31:0] out_data;

  modport master (
    output w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, out_ready,
    input  out_valid, out_pc, out_addr, out_data
  );

  modport slave (
    input  w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, out_ready,
    output out_valid, out_pc, out_addr, out_data
  );
endinterface

// File: rtl/grf_trace_sink.sv
// Write-back trace sink: record FIFO toward the host, shadow register file for
// debug reads, and committed-write / dropped-record counters. Never stalls the core.
module grf_trace_sink #(
  parameter int DEPTH       = 4,
  parameter bit FILTER_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  grf_trace_sink_if.slave         trace,
  input  logic [4:0]              shadow_raddr,
  output logic [31:0]             shadow_rdata,
  output logic [31:0]             wr_count,
  output logic [15:0]             drop_count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_wr_ptr;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [4:0]    r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_shadow   [32];
  logic [31:0]   r_wr_count;
  logic [15:0]   r_drop_count;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_cap;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;

  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_empty  = (r_rd_ptr == r_wr_ptr);
  assign w_full   = (r_rd_ptr[AW] != r_wr_ptr[AW]) && (w_rd_idx == w_wr_idx);

  assign w_cap  = trace.w_grf_we && !(FILTER_ZERO && (trace.w_grf_addr == 5'd0));
  assign w_pop  = !w_empty && trace.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  assign trace.out_valid = !w_empty;
  assign trace.out_pc    = w_empty ? 32'd0 : r_mem_pc[w_rd_idx];
  assign trace.out_addr  = w_empty ? 5'd0  : r_mem_addr[w_rd_idx];
  assign trace.out_data  = w_empty ? 32'd0 : r_mem_data[w_rd_idx];

  assign shadow_rdata = (shadow_raddr == 5'd0) ? 32'd0 : r_shadow[shadow_raddr];
  assign wr_count     = r_wr_count;
  assign drop_count   = r_drop_count;
  assign overflow     = r_overflow;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem_pc[w_wr_idx]   <= trace.w_inst_addr;
      r_mem_addr[w_wr_idx] <= trace.w_grf_addr;
      r_mem_data[w_wr_idx] <= trace.w_grf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
    end else if (w_cap && (trace.w_grf_addr != 5'd0)) begin
      r_shadow[trace.w_grf_addr] <= trace.w_grf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_count   <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_cap) r_wr_count <= r_wr_count + 32'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_grf_trace_sink.sv
// Directed bench for grf_trace_sink: scoreboard queue of expected records checked
// by an independent monitor, plus direct checks of counters and the shadow file.
module tb_grf_trace_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  shadow_raddr, shadow_raddr1;
  logic [31:0] shadow_rdata, shadow_rdata1;
  logic [31:0] wr_count, wr_count1;
  logic [15:0] drop_count, drop_count1;
  logic        overflow, overflow1;

  int errors = 0;
  int checks = 0;
  logic [68:0] exp_q[$];

  grf_trace_sink_if bus ();
  grf_trace_sink_if bus1 ();

  grf_trace_sink #(.DEPTH(4), .FILTER_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .trace(bus.slave),
    .shadow_raddr(shadow_raddr), .shadow_rdata(shadow_rdata),
    .wr_count(wr_count), .drop_count(drop_count), .overflow(overflow)
  );

  grf_trace_sink #(.DEPTH(4), .FILTER_ZERO(1'b0)) dut1 (
    .clk(clk), .reset(reset), .trace(bus1.slave),
    .shadow_raddr(shadow_raddr1), .shadow_rdata(shadow_rdata1),
    .wr_count(wr_count1), .drop_count(drop_count1), .overflow(overflow1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [31:0] pc, input bit kept);
    bus.w_grf_we    = 1'b1;
    bus.w_grf_addr  = a;
    bus.w_grf_wdata = d;
    bus.w_inst_addr = pc;
    if (kept) exp_q.push_back({pc, a, d});
  endtask

  task automatic idle();
    bus.w_grf_we    = 1'b0;
    bus.w_grf_addr  = 5'd0;
    bus.w_grf_wdata = 32'd0;
    bus.w_inst_addr = 32'd0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d records still expected", name, exp_q.size());
    end
  endtask

  task automatic check_shadow_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      shadow_raddr = 5'(a);
      #1;
      check(name, {37'd0, shadow_rdata}, 69'd0);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected none",
                 {bus.out_pc, bus.out_addr, bus.out_data});
      end else begin
        check("head_rec", {bus.out_pc, bus.out_addr, bus.out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    shadow_raddr   = 5'd0;
    shadow_raddr1  = 5'd0;
    bus.out_ready  = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.w_grf_we = 1'b0; bus1.w_grf_addr = 5'd0;
    bus1.w_grf_wdata = 32'd0; bus1.w_inst_addr = 32'd0;

    // Reset with the core writing: nothing must be captured.
    reset = 1'b0;
    bus.w_grf_we = 1'b1; bus.w_grf_addr = 5'd3;
    bus.w_grf_wdata = 32'hDEADBEEF; bus.w_inst_addr = 32'h100;
    tick(); tick();
    check("rst_valid", {68'd0, bus.out_valid}, 69'd0);
    check("rst_wr_count", {37'd0, wr_count}, 69'd0);
    check_shadow_zero("rst_shadow");
    idle();
    reset = 1'b1;
    tick(); tick();
    check("idle_valid", {68'd0, bus.out_valid}, 69'd0);
    check("idle_wr_count", {37'd0, wr_count}, 69'd0);
    check("idle_head", {bus.out_pc, bus.out_addr, bus.out_data}, 69'd0);

    // Single write, head held while out_ready is low.
    drive_write(5'd5, 32'h12345678, 32'h00003000, 1'b1);
    tick();
    idle();
    shadow_raddr = 5'd5;
    for (int k = 0; k < 3; k++) begin
      check("single_valid", {68'd0, bus.out_valid}, 69'd1);
      check("single_head", {bus.out_pc, bus.out_addr, bus.out_data},
            {32'h00003000, 5'd5, 32'h12345678});
      tick();
    end
    check("single_wr_count", {37'd0, wr_count}, 69'd1);
    check("single_shadow", {37'd0, shadow_rdata}, {37'd0, 32'h12345678});
    bus.out_ready = 1'b1;
    wait_drain("single_drain");
    bus.out_ready = 1'b0;

    // Register-0 writes: filtered on dut, captured on dut1.
    drive_write(5'd0, 32'hFFFFFFFF, 32'h00004000, 1'b0);
    bus1.w_grf_we = 1'b1; bus1.w_grf_addr = 5'd0;
    bus1.w_grf_wdata = 32'hFFFFFFFF; bus1.w_inst_addr = 32'h00004000;
    tick();
    idle();
    bus1.w_grf_we = 1'b0;
    shadow_raddr = 5'd0;
    shadow_raddr1 = 5'd0;
    #1;
    check("fz1_valid", {68'd0, bus.out_valid}, 69'd0);
    check("fz1_wr_count", {37'd0, wr_count}, 69'd1);
    check("fz1_shadow0", {37'd0, shadow_rdata}, 69'd0);
    check("fz0_valid", {68'd0, bus1.out_valid}, 69'd1);
    check("fz0_head", {bus1.out_pc, bus1.out_addr, bus1.out_data},
          {32'h00004000, 5'd0, 32'hFFFFFFFF});
    check("fz0_wr_count", {37'd0, wr_count1}, 69'd1);
    check("fz0_shadow0", {37'd0, shadow_rdata1}, 69'd0);

    // Overflow: six writes into a four-entry FIFO with no consumer.
    for (int i = 1; i <= 6; i++) begin
      drive_write(5'(i), 32'hA0000000 + 32'(i), 32'h100 + 32'(4 * i), i <= 4);
      tick();
    end
    idle();
    shadow_raddr = 5'd6;
    #1;
    check("ovf_drop_count", {53'd0, drop_count}, 69'd2);
    check("ovf_flag", {68'd0, overflow}, 69'd1);
    check("ovf_wr_count", {37'd0, wr_count}, 69'd7);
    check("ovf_shadow6", {37'd0, shadow_rdata}, {37'd0, 32'hA0000006});

    // Full FIFO with simultaneous pop and push: no drop, record 7 drains last.
    bus.out_ready = 1'b1;
    drive_write(5'd7, 32'hA0000007, 32'h0000011C, 1'b1);
    tick();
    idle();
    wait_drain("full_pop_push_drain");
    check("fpp_drop_count", {53'd0, drop_count}, 69'd2);
    check("fpp_valid_after", {68'd0, bus.out_valid}, 69'd0);

    // Streaming push and pop across several pointer wraps.
    for (int i = 0; i < 13; i++) begin
      drive_write(5'((i % 31) + 1), 32'hC0DE0000 + 32'(i), 32'h2000 + 32'(4 * i), 1'b1);
      tick();
    end
    idle();
    wait_drain("stream_drain");
    check("stream_drop_count", {53'd0, drop_count}, 69'd2);
    check("stream_wr_count", {37'd0, wr_count}, 69'd21);

    // Mid-stream reset: a push in the reset cycle is discarded.
    for (int i = 0; i < 5; i++) begin
      drive_write(5'(i + 1), 32'hBEEF0000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b1);
      tick();
    end
    reset = 1'b0;
    drive_write(5'd10, 32'h55555555, 32'h4444, 1'b0);
    tick();
    exp_q.delete();
    reset = 1'b1;
    idle();
    check("mrst_valid", {68'd0, bus.out_valid}, 69'd0);
    check("mrst_wr_count", {37'd0, wr_count}, 69'd0);
    check("mrst_drop_count", {53'd0, drop_count}, 69'd0);
    check("mrst_overflow", {68'd0, overflow}, 69'd0);
    check("mrst_dut1_valid", {68'd0, bus1.out_valid}, 69'd0);
    check("mrst_dut1_wr_count", {37'd0, wr_count1}, 69'd0);
    check_shadow_zero("mrst_shadow");

    // Block resumes normally after reset.
    drive_write(5'd9, 32'h0000ABCD, 32'h00005000, 1'b1);
    tick();
    idle();
    wait_drain("post_rst_drain");
    check("post_rst_wr_count", {37'd0, wr_count}, 69'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grf_trace_sink.md
Name: grf_trace_sink

Overview:
- Consumer end of the core's write-back trace interface (w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr) at the W stage.
- Captures every qualifying register-file write into a record FIFO and drains records over a valid/ready port to the simulation host or UART bridge.
- Keeps a shadow 32x32 register file for debug reads.
- Counts committed writes and dropped records.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- FILTER_ZERO, 1, 1 = ignore writes to register 0; 0 = capture them into the FIFO (shadow reg 0 always stays 0).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- w_grf_we  in  1  write-back enable from core
- w_grf_addr  in  5  destination register
- w_grf_wdata  in  32  write data
- w_inst_addr  in  32  PC of the writing instruction
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_pc  out  32  head record PC
- out_addr  out  5  head record register
- out_data  out  32  head record data
- shadow_raddr  in  5  debug read address
- shadow_rdata  out  32  shadow register value; combinational; 0 for address 0
- wr_count  out  32  qualifying writes captured since reset; wraps 0xFFFFFFFF -> 0
- drop_count  out  16  records lost to full FIFO; saturates at 0xFFFF
- overflow  out  1  sticky; set on first drop; cleared only by reset

Behaviour:
- Reset (reset==0 at clk edge):
  - FIFO empty; out_valid=0.
  - out_pc, out_addr and out_data read 0 while empty.
  - All 32 shadow regs = 0.
  - wr_count=0, drop_count=0, overflow=0.
  - A push or pop in the same cycle as reset is discarded.
- Qualify: cap = w_grf_we && !(FILTER_ZERO && w_grf_addr==0).
- Shadow write on cap && w_grf_addr!=0: shadow[w_grf_addr] <= w_grf_wdata next edge.
  - Shadow updates even when the FIFO record is dropped.
  - shadow_rdata does not bypass a same-cycle write; the new value is visible from the next cycle.
- wr_count increments on every cap, regardless of FIFO state.
- FIFO:
  - Circular buffer, rd_ptr/wr_ptr of log2(DEPTH)+1 bits.
  - empty = ptrs equal; full = MSBs differ and lower bits equal.
  - pop = out_valid && out_ready.
  - push = cap && (!full || pop): a simultaneous pop frees the slot, so a full FIFO with pop and push stays full with no drop.
  - drop = cap && full && !pop: drop_count += 1 (saturating) and overflow <= 1.
  - Push and pop on an empty FIFO: push only. No fall-through; out_valid rises the cycle after the first push (write-to-output latency 1 cycle).
  - Head outputs are registered/array-read from rd_ptr; they are stable while out_valid && !out_ready.
  - out_valid never drops without a pop. Order is strictly FIFO.
  - Pointer wrap-around at DEPTH is handled by the extra MSB; no entry is lost or duplicated across wrap.
- Core backpressure: none. The core never stalls on this block, and a lost record is reported only through drop_count/overflow.

Test Plan:
- Reset held low 2 cycles with w_grf_we=1 -> out_valid=0, wr_count=0, shadow_rdata=0 for every address; after release, all stay idle until the first cap.
- Single write we=1, addr=5, data=0x12345678, pc=0x00003000, out_ready=0 -> next cycle:
  - out_valid=1, out_pc=0x3000, out_addr=5, out_data=0x12345678, wr_count=1.
  - shadow_raddr=5 returns 0x12345678.
  - Holding out_ready=0 keeps all head fields stable.
- FILTER_ZERO=1, we=1 addr=0 data=0xFFFFFFFF -> no record, wr_count unchanged, shadow_rdata(0)=0; with FILTER_ZERO=0, one record with addr=0, and shadow(0) still reads 0.
- DEPTH=4, out_ready=0, 6 consecutive writes addr=1..6 -> FIFO holds 1..4, drop_count=2, overflow=1, wr_count=6, shadow(6)=data of write 6; then out_ready=1 drains addr 1,2,3,4 in order, and out_valid=0 after the 4th pop.
- Full FIFO with out_ready=1 and write addr=7 in the same cycle -> no drop (drop_count unchanged); 7 is the last record drained.
- Continuous push and pop for 3*DEPTH+1 cycles (ptr wrap) -> output sequence equals input sequence exactly, drop_count=0; mid-stream reset low for 1 cycle -> out_valid=0 the next cycle and all counters and the shadow file cleared.
